axis_rx_byte_packer: RTL and testbench
======================================

# axis_rx_byte_packer

Packs the byte-wide Ethernet receive stream (one byte per cycle from the MAC RX path) into DataWidth-wide AXI-Stream words for the clock-domain-crossing FIFO directly downstream. Runs entirely in the source (MAC) clock domain. It attaches tkeep/tstrb/tid/tdest/tuser sideband and keeps frame and error statistics. Sustained input rate is one byte per cycle with no bubbles unless downstream backpressure fills both internal word slots.

## Interface
- DataWidth, 64, output word width; multiple of 8, at least 16; Lanes = DataWidth/8
- IdWidth, 5, width of tid_o and cfg_tid_i
- DestWidth, 5, width of tdest_o and cfg_tdest_i
- CntWidth, 32, width of statistics counters
- clk_src_i  in  1  source/MAC clock
- rstn_src_i  in  1  reset; asynchronous, active-low (clock clk_src_i)
- in_tdata_i  in  8  received byte
- in_tvalid_i  in  1  byte valid
- in_tlast_i  in  1  last byte of frame
- in_tuser_i  in  1  byte error (PHY/CRC error marker)
- in_tready_o  out  1  byte accepted when in_tvalid_i && in_tready_o
- cfg_tid_i  in  IdWidth  stream id, sampled at each frame's first byte
- cfg_tdest_i  in  DestWidth  destination, sampled at each frame's first byte
- tdata_o  out  DataWidth  packed word, byte k on bits [8k+7:8k]
- tkeep_o / tstrb_o  out  Lanes  valid-lane mask; tstrb_o always equals tkeep_o
- tlast_o  out  1  word holds the frame's last byte
- tid_o / tdest_o  out  IdWidth / DestWidth  frame's sampled cfg values
- tuser_o  out  1  frame error; asserted on the last word only
- tvalid_o / tready_i  out / in  1 / 1  AXI-Stream handshake to CDC FIFO
- frame_cnt_o  out  CntWidth  frames emitted (tlast word handshaken), wraps
- err_cnt_o  out  CntWidth  frames emitted with tuser_o=1, wraps

## Operation
- Two storage slots: accumulator (acc, byte index idx, acc_full flag) and output register (the tdata_o..tuser_o set plus tvalid_o).
- Reset values: tvalid_o=0; tdata_o, tkeep_o, tstrb_o, tlast_o, tid_o, tdest_o, tuser_o=0; counters=0; idx=0; acc_full=0; sof=1; err_sticky=0. in_tready_o=!acc_full, so it reads 1 out of reset.
- Byte accept: write the byte into acc lane idx and set keep bit idx. If sof, capture cfg_tid_i/cfg_tdest_i and clear sof. err_sticky |= in_tuser_i.
- Word completion occurs on an accepted byte with idx==Lanes-1 or in_tlast_i=1.
  - If the output slot is free or being freed this cycle (!tvalid_o || tready_i), load the word straight into the output register.
  - Otherwise set acc_full=1.
  - tlast_o = in_tlast_i; tuser_o = in_tlast_i && (err_sticky || in_tuser_i).
  - idx returns to 0. On tlast, set sof=1 and clear err_sticky.
- acc_full=1: in_tready_o=0. When (!tvalid_o || tready_i), move acc to the output register and clear acc_full.
- Non-completing accept: idx increments.
- Lanes above the last valid byte are driven 0 in tdata_o, and their tkeep_o bits are 0.
- On handshake (tvalid_o && tready_i) with no new load, tvalid_o falls. The output register holds stable while tvalid_o && !tready_i.
- Counters increment on a handshake with tlast_o=1. err_cnt_o additionally requires tuser_o=1. Both wrap modulo 2^CntWidth.
- Reset mid-frame discards partial acc and output contents. The next accepted byte starts a new frame.

## Timing
- Latency: the completing byte accepted at cycle N gives tvalid_o=1 at N+1 (output slot free).
- in_tready_o is combinational from registered acc_full only; no combinational path from tready_i.
- Back-to-back words with tready_i=1 incur zero input stalls.
- Backpressure:
  - The first stalled word occupies the output register. Input continues filling acc.
  - When acc completes, in_tready_o drops the next cycle.
  - in_tready_o returns 1 the cycle after the tready_i handshake that moves acc to the output register.
- Simultaneous events: acc-to-output move and a new byte accept cannot coincide (in_tready_o=0 while acc_full). A direct load and an output handshake in the same cycle keep tvalid_o=1 with the new word.

## Test plan
- 8 bytes 0x00..0x07, tlast on 0x07, tready_i=1 → one word with tdata_o=0x0706050403020100, tkeep_o=0xFF, tlast_o=1, tuser_o=0, at the cycle after byte 7. frame_cnt_o=1.
- 11-byte frame 0x10..0x1A → word 1 tkeep_o=0xFF, tlast_o=0; word 2 tdata_o=0x00000000001A1918, tkeep_o=0x07, tlast_o=1.
- 1-byte frame 0xAB with cfg_tid_i=3, cfg_tdest_i=9, then cfg changed mid-idle → tkeep_o=0x01, tid_o=3, tdest_o=9. The next frame carries the new values.
- 24-byte frame, tready_i=0 from the first tvalid_o for 20 cycles:
  - in_tready_o=0 after byte 16 is accepted.
  - No byte is lost or duplicated.
  - After tready_i=1, three words with tdata_o in order.
- Frame with in_tuser_i=1 on byte 2 of 12 → word 1 tuser_o=0, word 2 tuser_o=1. err_cnt_o=1. Next clean frame has tuser_o=0.
- Assert rstn_src_i mid-frame after 5 bytes → all outputs at reset values. A following 8-byte frame packs from lane 0 correctly.

Source files
------------

// File: rtl/axis_rx_byte_packer.sv
// -----------------------------------------------------------------------------
// axis_rx_byte_packer
//
// Packs the byte-wide Ethernet receive stream from the MAC RX path into
// DataWidth-wide AXI-Stream words for the clock-domain-crossing FIFO that sits
// directly downstream. Everything runs in the source (MAC) clock domain.
//
// Storage is two word slots:
//   - accumulator : bytes of the word being built (acc_data/acc_keep), the
//                   lane index of the next byte (idx) and acc_full, which marks
//                   a completed word still waiting for the output slot.
//   - output reg  : tdata_o..tuser_o plus tvalid_o, held stable under
//                   backpressure.
// A full input rate of one byte per cycle is sustained as long as the
// downstream consumer does not stall long enough to fill both slots.
//
// Ports
//   clk_src_i, rstn_src_i     source clock, asynchronous active-low reset
//   in_tdata_i/in_tvalid_i/   byte stream from the MAC; in_tuser_i flags a
//   in_tlast_i/in_tuser_i     byte carrying a PHY/CRC error
//   in_tready_o               byte taken when in_tvalid_i && in_tready_o
//   cfg_tid_i/cfg_tdest_i     stream id / destination, sampled on each
//                             frame's first byte
//   tdata_o/tkeep_o/tstrb_o   packed word, byte k on bits [8k+7:8k]; unused
//                             upper lanes are zero with their keep bits clear
//   tlast_o/tuser_o           last word of frame / frame had an error
//                             (tuser_o only ever set on the last word)
//   tid_o/tdest_o             cfg values captured at the frame's first byte
//   tvalid_o/tready_i         AXI-Stream handshake towards the CDC FIFO
//   frame_cnt_o/err_cnt_o     frames emitted / frames emitted with an error,
//                             both wrapping
// -----------------------------------------------------------------------------
module axis_rx_byte_packer #(
  parameter int DataWidth = 64,
  parameter int IdWidth   = 5,
  parameter int DestWidth = 5,
  parameter int CntWidth  = 32
) (
  input  logic                   clk_src_i,
  input  logic                   rstn_src_i,

  input  logic [7:0]             in_tdata_i,
  input  logic                   in_tvalid_i,
  input  logic                   in_tlast_i,
  input  logic                   in_tuser_i,
  output logic                   in_tready_o,

  input  logic [IdWidth-1:0]     cfg_tid_i,
  input  logic [DestWidth-1:0]   cfg_tdest_i,

  output logic [DataWidth-1:0]   tdata_o,
  output logic [DataWidth/8-1:0] tkeep_o,
  output logic [DataWidth/8-1:0] tstrb_o,
  output logic                   tlast_o,
  output logic [IdWidth-1:0]     tid_o,
  output logic [DestWidth-1:0]   tdest_o,
  output logic                   tuser_o,
  output logic                   tvalid_o,
  input  logic                   tready_i,

  output logic [CntWidth-1:0]    frame_cnt_o,
  output logic [CntWidth-1:0]    err_cnt_o
);

  localparam int Lanes    = DataWidth / 8;
  localparam int IdxWidth = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Lanes - 1);

  // Accumulator slot
  logic [DataWidth-1:0] acc_data;
  logic [Lanes-1:0]     acc_keep;
  logic                 acc_last;
  logic                 acc_user;
  logic [IdxWidth-1:0]  idx;
  logic                 acc_full;

  // Frame tracking
  logic                 sof;
  logic                 err_sticky;
  logic [IdWidth-1:0]   frame_id;
  logic [DestWidth-1:0] frame_dest;

  // Handshake / event decode
  logic accept;
  logic complete;
  logic out_free;
  logic out_fire;
  logic move_acc;
  logic load_direct;

  // Word as it would look with the current byte merged in
  logic [DataWidth-1:0] word_data;
  logic [Lanes-1:0]     word_keep;
  logic [IdWidth-1:0]   word_id;
  logic [DestWidth-1:0] word_dest;
  logic                 word_user;

  // Ready depends only on registered state, so there is no combinational path
  // from tready_i back to the MAC.
  assign in_tready_o = !acc_full;
  assign tstrb_o     = tkeep_o;

  assign accept      = in_tvalid_i && !acc_full;
  assign out_free    = !tvalid_o || tready_i;
  assign out_fire    = tvalid_o && tready_i;
  assign complete    = accept && ((idx == LastIdx) || in_tlast_i);
  // A parked word and a new byte never coincide: ready is low while parked.
  assign move_acc    = acc_full && out_free;
  assign load_direct = complete && out_free;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    word_data[{idx, 3'b000} +: 8] = in_tdata_i;
    word_keep[idx]                = 1'b1;
    // The first byte of a frame uses the live cfg value; later words reuse
    // the copy captured on that byte.
    word_id   = sof ? cfg_tid_i   : frame_id;
    word_dest = sof ? cfg_tdest_i : frame_dest;
    word_user = in_tlast_i && (err_sticky || in_tuser_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and later statements may override earlier
  // ones within the same edge without ordering races.
  always_ff @(posedge clk_src_i or negedge rstn_src_i) begin
    if (!rstn_src_i) begin
      // NOTE: the accumulator is reset along with the control bits so that a
      // reset mid-frame cannot leak stale bytes into the upper lanes of the
      // next frame's first word.
      acc_data    <= '0;
      acc_keep    <= '0;
      acc_last    <= 1'b0;
      acc_user    <= 1'b0;
      idx         <= '0;
      acc_full    <= 1'b0;
      sof         <= 1'b1;
      err_sticky  <= 1'b0;
      frame_id    <= '0;
      frame_dest  <= '0;
      tdata_o     <= '0;
      tkeep_o     <= '0;
      tlast_o     <= 1'b0;
      tid_o       <= '0;
      tdest_o     <= '0;
      tuser_o     <= 1'b0;
      tvalid_o    <= 1'b0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      // ---------------- accumulator side ----------------
      if (accept) begin
        if (sof) begin
          frame_id   <= cfg_tid_i;
          frame_dest <= cfg_tdest_i;
        end
        sof <= 1'b0;

        if (complete) begin
          idx <= '0;
          if (in_tlast_i) begin
            sof        <= 1'b1;
            err_sticky <= 1'b0;
          end else begin
            err_sticky <= err_sticky || in_tuser_i;
          end

          if (out_free) begin
            // Word goes straight to the output; start the next one empty so
            // unused upper lanes stay zero.
            acc_data <= '0;
            acc_keep <= '0;
          end else begin
            // Output busy: park the finished word and stop taking bytes.
            acc_data <= word_data;
            acc_keep <= word_keep;
            acc_last <= in_tlast_i;
            acc_user <= word_user;
            acc_full <= 1'b1;
          end
        end else begin
          idx        <= idx + IdxWidth'(1);
          acc_data   <= word_data;
          acc_keep   <= word_keep;
          err_sticky <= err_sticky || in_tuser_i;
        end
      end

      // ---------------- output side ----------------
      if (move_acc) begin
        // frame_id/frame_dest cannot have moved on: no byte is accepted while
        // a word is parked.
        tdata_o  <= acc_data;
        tkeep_o  <= acc_keep;
        tlast_o  <= acc_last;
        tuser_o  <= acc_user;
        tid_o    <= frame_id;
        tdest_o  <= frame_dest;
        tvalid_o <= 1'b1;
        acc_full <= 1'b0;
        acc_data <= '0;
        acc_keep <= '0;
      end else if (load_direct) begin
        tdata_o  <= word_data;
        tkeep_o  <= word_keep;
        tlast_o  <= in_tlast_i;
        tuser_o  <= word_user;
        tid_o    <= word_id;
        tdest_o  <= word_dest;
        tvalid_o <= 1'b1;
      end else if (out_fire) begin
        tvalid_o <= 1'b0;
      end

      // ---------------- statistics ----------------
      if (out_fire && tlast_o) begin
        frame_cnt_o <= frame_cnt_o + CntWidth'(1);
        if (tuser_o) begin
          err_cnt_o <= err_cnt_o + CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_rx_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_rx_byte_packer
//
// Directed scenarios followed by randomized frames under random backpressure.
// Expected words are built from each frame's byte list by chunking it into
// Lanes-byte groups; observed words are captured at every output handshake
// and compared in order.
// -----------------------------------------------------------------------------
module tb_axis_rx_byte_packer;

  localparam int DW  = 64;
  localparam int L   = DW / 8;
  localparam int IW  = 5;
  localparam int DSW = 5;
  localparam int CW  = 32;

  logic           clk_src_i;
  logic           rstn_src_i;
  logic [7:0]     in_tdata_i;
  logic           in_tvalid_i;
  logic           in_tlast_i;
  logic           in_tuser_i;
  logic           in_tready_o;
  logic [IW-1:0]  cfg_tid_i;
  logic [DSW-1:0] cfg_tdest_i;
  logic [DW-1:0]  tdata_o;
  logic [L-1:0]   tkeep_o;
  logic [L-1:0]   tstrb_o;
  logic           tlast_o;
  logic [IW-1:0]  tid_o;
  logic [DSW-1:0] tdest_o;
  logic           tuser_o;
  logic           tvalid_o;
  logic           tready_i;
  logic [CW-1:0]  frame_cnt_o;
  logic [CW-1:0]  err_cnt_o;

  axis_rx_byte_packer #(
    .DataWidth(DW), .IdWidth(IW), .DestWidth(DSW), .CntWidth(CW)
  ) dut (
    .clk_src_i  (clk_src_i),
    .rstn_src_i (rstn_src_i),
    .in_tdata_i (in_tdata_i),
    .in_tvalid_i(in_tvalid_i),
    .in_tlast_i (in_tlast_i),
    .in_tuser_i (in_tuser_i),
    .in_tready_o(in_tready_o),
    .cfg_tid_i  (cfg_tid_i),
    .cfg_tdest_i(cfg_tdest_i),
    .tdata_o    (tdata_o),
    .tkeep_o    (tkeep_o),
    .tstrb_o    (tstrb_o),
    .tlast_o    (tlast_o),
    .tid_o      (tid_o),
    .tdest_o    (tdest_o),
    .tuser_o    (tuser_o),
    .tvalid_o   (tvalid_o),
    .tready_i   (tready_i),
    .frame_cnt_o(frame_cnt_o),
    .err_cnt_o  (err_cnt_o)
  );

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [L-1:0]   keep;
    logic [L-1:0]   strb;
    logic           last;
    logic           user;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
  } word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  word_t mon_w;

  int checks      = 0;
  int errors      = 0;
  int exp_frames  = 0;
  int exp_errs    = 0;
  int first_stall = -1;
  int bp_mode     = 0;  // 0: ready, 1: random, 2: stall 20 cycles from first tvalid
  int stall_left  = 0;

  initial clk_src_i = 1'b0;
  always #5 clk_src_i = ~clk_src_i;

  // Global watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Monitor: values seen mid-cycle are the ones the next rising edge takes.
  always @(negedge clk_src_i) begin
    if (rstn_src_i && tvalid_o && tready_i) begin
      mon_w.data = tdata_o;
      mon_w.keep = tkeep_o;
      mon_w.strb = tstrb_o;
      mon_w.last = tlast_o;
      mon_w.user = tuser_o;
      mon_w.id   = tid_o;
      mon_w.dest = tdest_o;
      obs_q.push_back(mon_w);
    end
  end

  // Downstream ready generator
  initial begin
    tready_i = 1'b1;
    forever begin
      @(posedge clk_src_i);
      #1;
      case (bp_mode)
        0: tready_i = 1'b1;
        1: tready_i = ($urandom_range(0, 3) != 0);
        2: begin
          tready_i = 1'b0;
          if (tvalid_o) begin
            stall_left = 20;
            bp_mode    = 3;
          end
        end
        default: begin
          if (stall_left > 0) begin
            tready_i   = 1'b0;
            stall_left = stall_left - 1;
          end else begin
            tready_i = 1'b1;
            bp_mode  = 0;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk_src_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s word: observed data=%h keep=%h strb=%h last=%b user=%b id=%h dest=%h expected data=%h keep=%h strb=%h last=%b user=%b id=%h dest=%h",
             tag, obs.data, obs.keep, obs.strb, obs.last, obs.user, obs.id, obs.dest,
             exp.data, exp.keep, exp.strb, exp.last, exp.user, exp.id, exp.dest);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " tvalid_o"},    tvalid_o,    0);
    check({tag, " tdata_o"},     tdata_o,     0);
    check({tag, " tkeep_o"},     tkeep_o,     0);
    check({tag, " tstrb_o"},     tstrb_o,     0);
    check({tag, " tlast_o"},     tlast_o,     0);
    check({tag, " tid_o"},       tid_o,       0);
    check({tag, " tdest_o"},     tdest_o,     0);
    check({tag, " tuser_o"},     tuser_o,     0);
    check({tag, " frame_cnt_o"}, frame_cnt_o, 0);
    check({tag, " err_cnt_o"},   err_cnt_o,   0);
    check({tag, " in_tready_o"}, in_tready_o, 1);
  endtask

  // Builds the expected words for one frame, then drives its bytes.
  // err_pos < 0 means a clean frame.
  task automatic run_frame(input int len, input logic [IW-1:0] id, input logic [DSW-1:0] dest,
                           input int err_pos, input logic [7:0] base, input bit rnd);
    logic [7:0] b[$];
    word_t w;
    int nw;
    for (int i = 0; i < len; i++) b.push_back(rnd ? 8'($urandom) : 8'(base + i));

    nw = (len + L - 1) / L;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int k = 0; k < L; k++) begin
        if (wi * L + k < len) begin
          w.data[8*k +: 8] = b[wi*L + k];
          w.keep[k]        = 1'b1;
        end
      end
      w.strb = w.keep;
      w.last = (wi == nw - 1);
      w.user = w.last && (err_pos >= 0);
      w.id   = id;
      w.dest = dest;
      exp_q.push_back(w);
    end
    exp_frames++;
    if (err_pos >= 0) exp_errs++;

    first_stall = -1;
    cfg_tid_i   = id;
    cfg_tdest_i = dest;
    for (int i = 0; i < len; i++) begin
      int budget;
      in_tdata_i  = b[i];
      in_tlast_i  = (i == len - 1);
      in_tuser_i  = (i == err_pos);
      in_tvalid_i = 1'b1;
      budget = 0;
      forever begin
        @(negedge clk_src_i);
        if (in_tready_o) break;
        if (first_stall < 0) first_stall = i;
        budget++;
        if (budget > 500) begin
          checks++;
          errors++;
          $error("FAIL byte accept timeout: byte %0d of %0d not accepted", i, len);
          break;
        end
      end
      step();
      if (i == 0) begin
        // Scramble cfg after the first byte: later words must keep the sample.
        cfg_tid_i   = IW'($urandom);
        cfg_tdest_i = DSW'($urandom);
      end
    end
    in_tvalid_i = 1'b0;
    in_tlast_i  = 1'b0;
    in_tuser_i  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      step();
      n++;
    end
    step();
    step();
    check({tag, " word count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) check_word(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    check({tag, " frame_cnt_o"}, frame_cnt_o, exp_frames);
    check({tag, " err_cnt_o"},   err_cnt_o,   exp_errs);
  endtask

  initial begin
    rstn_src_i  = 1'b0;
    in_tdata_i  = '0;
    in_tvalid_i = 1'b0;
    in_tlast_i  = 1'b0;
    in_tuser_i  = 1'b0;
    cfg_tid_i   = '0;
    cfg_tdest_i = '0;
    repeat (3) @(posedge clk_src_i);
    #1;
    check_reset_state("por");
    rstn_src_i = 1'b1;
    step();

    // Single full word, latency and content right after the completing byte
    bp_mode = 0;
    run_frame(8, 5'd0, 5'd0, -1, 8'h00, 1'b0);
    check("t1 latency tvalid_o", tvalid_o, 1);
    check("t1 tdata_o", tdata_o, 64'h0706050403020100);
    check("t1 tkeep_o", tkeep_o, 8'hFF);
    check("t1 tlast_o", tlast_o, 1);
    check("t1 tuser_o", tuser_o, 0);
    drain("t1");

    // Partial last word, no input stalls with downstream ready
    run_frame(11, 5'd1, 5'd2, -1, 8'h10, 1'b0);
    check("t2 no input stall", first_stall, -1);
    drain("t2");

    // 1-byte frame, then cfg change while idle
    run_frame(1, 5'd3, 5'd9, -1, 8'hAB, 1'b0);
    cfg_tid_i   = 5'd7;
    cfg_tdest_i = 5'd12;
    repeat (3) step();
    run_frame(3, 5'd7, 5'd12, -1, 8'h40, 1'b0);
    drain("t3");

    // Backpressure: 20-cycle stall from the first tvalid
    bp_mode = 2;
    run_frame(24, 5'd4, 5'd5, -1, 8'h60, 1'b0);
    check("t4 bytes accepted before stall", first_stall, 16);
    drain("t4");
    bp_mode = 0;

    // Error on byte 2 of 12, then a clean frame
    run_frame(12, 5'd6, 5'd7, 2, 8'h20, 1'b0);
    drain("t5 err");
    run_frame(8, 5'd8, 5'd9, -1, 8'h30, 1'b0);
    drain("t5 clean");

    // Randomized frames under random backpressure
    bp_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      int ep;
      len = $urandom_range(1, 20);
      ep  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_frame(len, IW'($urandom), DSW'($urandom), ep, 8'h00, 1'b1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) step();
    end
    drain("rnd");
    bp_mode = 0;
    step();

    // Reset after 5 bytes of a frame
    for (int i = 0; i < 5; i++) begin
      in_tdata_i  = 8'(8'hC0 + i);
      in_tvalid_i = 1'b1;
      step();
    end
    in_tvalid_i = 1'b0;
    rstn_src_i  = 1'b0;
    #2;
    check_reset_state("mid rst");
    exp_frames = 0;
    exp_errs   = 0;
    exp_q.delete();
    obs_q.delete();
    step();
    rstn_src_i = 1'b1;
    step();
    run_frame(8, 5'd10, 5'd11, -1, 8'h80, 1'b0);
    drain("post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
